ntt_job_arbiter: RTL and testbench

Scheduler that shares one `ntt_memory_wrapper` between two job requesters: forward NTT (requester 0) and inverse NTT (requester 1). It grants the wrapper round-robin, then sequences one job: wrapper reset, start, finish detection, drain. While a job runs it routes the wrapper's memory port to the granted requester's coefficient bank. It also reports per-job cycle counts and a watchdog timeout.

---
 rtl/ntt_job_arbiter.sv | 167 ++++++++++++++++
 tb/tb_ntt_job_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_job_arbiter.sv
// Shares one NTT memory wrapper between a forward (0) and an inverse (1) requester.
// Grants round-robin, then sequences one job: wrapper reset, run, finish edge or
// watchdog timeout, drain, done. The wrapper's memory port is steered to the granted
// requester's coefficient bank while the job owns it.
module ntt_job_arbiter #(
  parameter int unsigned LOGN    = 8,
  parameter int unsigned LOGQ    = 64,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned DRAIN   = 2,
  localparam int unsigned AW     = (LOGN < 9) ? 10 : LOGN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req,
  output logic [1:0]      gnt,
  output logic [1:0]      done,
  output logic            busy,
  output logic            err,
  output logic [31:0]     cycles,
  output logic            ntt_rst,
  output logic            ntt_start,
  output logic            ntt_intt,
  input  logic            ntt_finish,
  input  logic [AW-1:0]   ntt_rd_addr,
  input  logic [AW-1:0]   ntt_wr_addr,
  input  logic            ntt_wea,
  input  logic [LOGQ-1:0] ntt_dout,
  output logic [LOGQ-1:0] ntt_din,
  output logic [AW-1:0]   mem_rd_addr,
  output logic [AW-1:0]   mem_wr_addr,
  output logic [1:0]      mem_wea,
  output logic [LOGQ-1:0] mem_wr_data,
  input  logic [LOGQ-1:0] mem_rd_data0,
  input  logic [LOGQ-1:0] mem_rd_data1
);

  localparam int unsigned DrainW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN - 1);
  localparam logic [31:0] TimeoutCnt = 32'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StRun,
    StDrain,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              last_q, last_d;     // index of the requester served last
  logic [31:0]       run_cnt_q, run_cnt_d;
  logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;
  logic              finish_q;
  logic              err_q, err_d;
  logic [31:0]       cycles_q, cycles_d;

  logic              start_rst;
  logic              route_wr;
  logic [31:0]       run_cnt_inc;

  assign run_cnt_inc = run_cnt_q + 32'd1;

  // Next-state logic and per-state wrapper controls
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    run_cnt_d   = run_cnt_q;
    drain_cnt_d = drain_cnt_q;
    err_d       = err_q;
    cycles_d    = cycles_q;
    start_rst   = 1'b0;
    route_wr    = 1'b0;
    ntt_start   = 1'b0;
    done        = 2'b00;

    unique case (state_q)
      StIdle: begin
        if (req != 2'b00) begin
          // On contention the requester not served last wins
          if (req == 2'b11) begin
            gnt_d = last_q ? 2'b01 : 2'b10;
          end else begin
            gnt_d = req;
          end
          state_d = StStart;
        end
      end
      StStart: begin
        start_rst = 1'b1;
        route_wr  = 1'b1;
        run_cnt_d = '0;
        state_d   = StRun;
      end
      StRun: begin
        ntt_start = 1'b1;
        route_wr  = 1'b1;
        run_cnt_d = run_cnt_inc;
        // A finish already high on entry has finish_q set, so it is not an edge
        if (ntt_finish && !finish_q) begin
          drain_cnt_d = '0;
          state_d     = StDrain;
        end else if (run_cnt_inc == TimeoutCnt) begin
          err_d       = 1'b1;
          drain_cnt_d = '0;
          state_d     = StDrain;
        end
      end
      StDrain: begin
        route_wr = 1'b1;
        if (drain_cnt_q == DrainLast) begin
          state_d = StDone;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      StDone: begin
        done     = gnt_q;
        cycles_d = run_cnt_q;
        last_d   = gnt_q[1];
        gnt_d    = 2'b00;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      gnt_q       <= 2'b00;
      last_q      <= 1'b1;
      run_cnt_q   <= '0;
      drain_cnt_q <= '0;
      finish_q    <= 1'b0;
      err_q       <= 1'b0;
      cycles_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      run_cnt_q   <= run_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      finish_q    <= ntt_finish;
      err_q       <= err_d;
      cycles_q    <= cycles_d;
    end
  end

  assign gnt      = gnt_q;
  assign busy     = (state_q != StIdle);
  assign err      = err_q;
  assign cycles   = cycles_q;
  assign ntt_rst  = ~rst | start_rst;
  assign ntt_intt = gnt_q[1];

  // Memory routing: addresses and write data pass through, the enable is steered
  assign mem_rd_addr = ntt_rd_addr;
  assign mem_wr_addr = ntt_wr_addr;
  assign mem_wr_data = ntt_dout;
  assign mem_wea     = route_wr ? (gnt_q & {2{ntt_wea}}) : 2'b00;
  assign ntt_din     = gnt_q[0] ? mem_rd_data0 :
                       gnt_q[1] ? mem_rd_data1 : '0;

endmodule

// File: tb/tb_ntt_job_arbiter.sv
// Randomized bench for ntt_job_arbiter: a noisy wrapper model and two registered-read
// banks drive the DUT; a timestamp-based job model predicts every output each cycle.
module tb_ntt_job_arbiter;

  localparam int unsigned LOGN    = 8;
  localparam int unsigned LOGQ    = 64;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned DRAIN   = 2;
  localparam int unsigned AW      = (LOGN < 9) ? 10 : LOGN;

  localparam int PhIdle  = 0;
  localparam int PhStart = 1;
  localparam int PhRun   = 2;
  localparam int PhDrain = 3;
  localparam int PhDone  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req, gnt, done, mem_wea;
  logic            busy, err, ntt_rst, ntt_start, ntt_intt, ntt_finish, ntt_wea;
  logic [31:0]     cycles;
  logic [AW-1:0]   ntt_rd_addr, ntt_wr_addr, mem_rd_addr, mem_wr_addr;
  logic [LOGQ-1:0] ntt_dout, ntt_din, mem_wr_data, mem_rd_data0, mem_rd_data1;

  always #5 clk = ~clk;

  ntt_job_arbiter #(
    .LOGN    (LOGN),
    .LOGQ    (LOGQ),
    .TIMEOUT (TIMEOUT),
    .DRAIN   (DRAIN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .gnt          (gnt),
    .done         (done),
    .busy         (busy),
    .err          (err),
    .cycles       (cycles),
    .ntt_rst      (ntt_rst),
    .ntt_start    (ntt_start),
    .ntt_intt     (ntt_intt),
    .ntt_finish   (ntt_finish),
    .ntt_rd_addr  (ntt_rd_addr),
    .ntt_wr_addr  (ntt_wr_addr),
    .ntt_wea      (ntt_wea),
    .ntt_dout     (ntt_dout),
    .ntt_din      (ntt_din),
    .mem_rd_addr  (mem_rd_addr),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wea      (mem_wea),
    .mem_wr_data  (mem_wr_data),
    .mem_rd_data0 (mem_rd_data0),
    .mem_rd_data1 (mem_rd_data1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Reference model: one job described by its grant index and phase timestamps
  bit m_active = 1'b0;
  int m_idx    = 0;
  int m_start  = 0;
  int m_fin    = -1;
  int m_last   = 1;
  bit m_err    = 1'b0;
  int m_cycles = 0;
  bit m_fq     = 1'b0;

  logic [LOGQ-1:0] bank0 [0:(1<<AW)-1];
  logic [LOGQ-1:0] bank1 [0:(1<<AW)-1];
  logic [LOGQ-1:0] exp_bank0 [0:31];
  logic [LOGQ-1:0] exp_bank1 [0:31];

  // Stimulus control
  int want0 = 0, want1 = 0;
  bit force_rst = 1'b1;
  bit rst_plan = 1'b0;
  bit never_finish = 1'b0;
  int len_lo = 3, len_hi = 30;
  int force_fin = 0;

  // Wrapper model
  bit w_run = 1'b0, w_fin = 1'b0;
  int w_left = 0;

  // DUT observations from the previous sample point
  logic            o_rst = 1'b1, o_start = 1'b0;
  logic [1:0]      o_wea = 2'b00, o_gnt = 2'b00;
  logic [AW-1:0]   o_wr_addr = '0, o_rd_addr = '0;
  logic [LOGQ-1:0] o_wr_data = '0;

  int dut_done_cnt = 0;
  int last_done_cyc = -1;
  int glog[$];
  int gaps[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic int phase_of(input int n);
    if (!m_active) return PhIdle;
    if (n == m_start) return PhStart;
    if (m_fin < 0 || n <= m_fin) return PhRun;
    if (n <= m_fin + int'(DRAIN)) return PhDrain;
    return PhDone;
  endfunction

  task automatic step();
    int ph;
    logic [LOGQ-1:0] r0, r1;
    logic [1:0] e_gnt;
    bit routed;
    @(posedge clk);
    #1;
    // Banks: registered read of last cycle's address, then last cycle's write
    r0 = bank0[o_rd_addr];
    r1 = bank1[o_rd_addr];
    if (o_wea[0]) bank0[o_wr_addr] = o_wr_data;
    if (o_wea[1]) bank1[o_wr_addr] = o_wr_data;
    mem_rd_data0 = r0;
    mem_rd_data1 = r1;

    // Model: account for the cycle that just ended, using its inputs
    ph = phase_of(cyc);
    if ((ph == PhStart || ph == PhRun || ph == PhDrain) && ntt_wea) begin
      if (m_idx == 0) exp_bank0[ntt_wr_addr[4:0]] = ntt_dout;
      else            exp_bank1[ntt_wr_addr[4:0]] = ntt_dout;
    end
    if (!rst) begin
      m_active = 1'b0;
      m_last   = 1;
      m_err    = 1'b0;
      m_cycles = 0;
      m_fq     = 1'b0;
    end else begin
      if (m_active) begin
        if (ph == PhRun && m_fin < 0) begin
          if (ntt_finish && !m_fq) begin
            m_fin = cyc;
          end else if (cyc - m_start == int'(TIMEOUT)) begin
            m_fin = cyc;
            m_err = 1'b1;
          end
        end else if (ph == PhDone) begin
          m_cycles = m_fin - m_start;
          m_last   = m_idx;
          m_active = 1'b0;
        end
      end else if (req != 2'b00) begin
        m_idx    = (req == 2'b11) ? 1 - m_last : (req[0] ? 0 : 1);
        m_active = 1'b1;
        m_start  = cyc + 1;
        m_fin    = -1;
      end
      m_fq = ntt_finish;
    end
    cyc++;

    // Requesters drop req in their done cycle once their job quota is used up
    ph = phase_of(cyc);
    if (ph == PhDone) begin
      if (m_idx == 0 && want0 > 0) want0--;
      if (m_idx == 1 && want1 > 0) want1--;
    end
    rst = !force_rst;
    if (rst_plan && ph == PhRun && cyc - m_start == 10) begin
      rst      = 1'b0;
      rst_plan = 1'b0;
      want0    = 0;
      want1    = 0;
    end
    req = {(want1 > 0), (want0 > 0)};

    // Wrapper reacts to the controls it saw last cycle
    if (o_rst) begin
      w_run = 1'b0;
      w_fin = 1'b0;
    end else if (w_run) begin
      w_left--;
      if (w_left == 0) begin
        w_run = 1'b0;
        w_fin = 1'b1;
      end
    end else if (o_start && !w_fin) begin
      w_run  = 1'b1;
      w_left = never_finish ? 1000000 : int'($urandom_range(len_hi, len_lo));
    end
    ntt_finish = w_fin || (force_fin > 0);
    if (force_fin > 0) force_fin--;
    ntt_wea     = 1'($urandom_range(0, 1));
    ntt_wr_addr = AW'($urandom_range(0, 31));
    ntt_rd_addr = AW'($urandom_range(0, 31));
    ntt_dout    = {$urandom(), $urandom()};

    @(negedge clk);
    ph     = phase_of(cyc);
    e_gnt  = !m_active ? 2'b00 : (m_idx == 1 ? 2'b10 : 2'b01);
    routed = (ph == PhStart || ph == PhRun || ph == PhDrain);
    check_eq("gnt", 64'(gnt), 64'(e_gnt));
    check_eq("done", 64'(done), 64'(ph == PhDone ? e_gnt : 2'b00));
    check_eq("busy", 64'(busy), 64'(m_active));
    check_eq("err", 64'(err), 64'(m_err));
    check_eq("cycles", 64'(cycles), 64'(m_cycles));
    check_eq("ntt_rst", 64'(ntt_rst), 64'(ph == PhStart || !rst));
    check_eq("ntt_start", 64'(ntt_start), 64'(ph == PhRun));
    check_eq("ntt_intt", 64'(ntt_intt), 64'(m_active && m_idx == 1));
    check_eq("mem_wea", 64'(mem_wea), 64'((routed && ntt_wea) ? e_gnt : 2'b00));
    check_eq("ntt_din", 64'(ntt_din),
             64'(!m_active ? '0 : (m_idx == 1 ? mem_rd_data1 : mem_rd_data0)));
    check_eq("rd_addr", 64'(mem_rd_addr), 64'(ntt_rd_addr));
    check_eq("wr_addr", 64'(mem_wr_addr), 64'(ntt_wr_addr));
    check_eq("wr_data", 64'(mem_wr_data), 64'(ntt_dout));

    if (done != 2'b00) begin
      dut_done_cnt++;
      last_done_cyc = cyc;
    end
    if (gnt != 2'b00 && o_gnt == 2'b00) begin
      glog.push_back(gnt[1] ? 1 : 0);
      if (last_done_cyc >= 0) gaps.push_back(cyc - last_done_cyc);
    end
    o_gnt     = gnt;
    o_rst     = ntt_rst;
    o_start   = ntt_start;
    o_wea     = mem_wea;
    o_wr_addr = mem_wr_addr;
    o_wr_data = mem_wr_data;
    o_rd_addr = mem_rd_addr;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int quiet;
    quiet = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (!m_active && want0 == 0 && want1 == 0) quiet++;
      else quiet = 0;
      if (quiet >= 3) break;
    end
    check_eq(tag, 64'(busy), 64'(0));
  endtask

  task automatic compare_banks();
    for (int a = 0; a < 32; a++) begin
      check_eq("bank0", bank0[a], exp_bank0[a]);
      check_eq("bank1", bank1[a], exp_bank1[a]);
    end
  endtask

  task automatic new_scenario();
    glog.delete();
    gaps.delete();
    last_done_cyc = -1;
  endtask

  initial begin
    int d0;
    for (int a = 0; a < (1 << AW); a++) begin
      bank0[a] = '0;
      bank1[a] = '0;
    end
    for (int a = 0; a < 32; a++) begin
      exp_bank0[a] = '0;
      exp_bank1[a] = '0;
    end
    rst = 1'b0; req = 2'b00; ntt_finish = 1'b0; ntt_wea = 1'b0;
    ntt_rd_addr = '0; ntt_wr_addr = '0; ntt_dout = '0;
    mem_rd_data0 = '0; mem_rd_data1 = '0;

    // Reset
    force_rst = 1'b1;
    repeat (3) step();
    check_eq("rst_ntt_rst", 64'(ntt_rst), 64'(1));
    check_eq("rst_gnt", 64'(gnt), 64'(0));
    force_rst = 1'b0;

    // Single forward job, dropped in its done cycle
    new_scenario();
    d0 = dut_done_cnt;
    want0 = 1;
    wait_idle("s1_idle", 200);
    check_eq("s1_done_cnt", 64'(dut_done_cnt - d0), 64'(1));
    compare_banks();

    // Simultaneous requests straight out of reset
    force_rst = 1'b1;
    repeat (2) step();
    force_rst = 1'b0;
    new_scenario();
    want0 = 1; want1 = 1;
    wait_idle("s2_idle", 300);
    check_eq("s2_njobs", 64'(glog.size()), 64'(2));
    for (int i = 0; i < 2; i++) check_eq("s2_order", 64'(i < glog.size() ? glog[i] : 7), 64'(i));
    compare_banks();

    // Fairness with both requests held for four jobs
    new_scenario();
    want0 = 2; want1 = 2;
    wait_idle("s3_idle", 500);
    check_eq("s3_njobs", 64'(glog.size()), 64'(4));
    for (int i = 0; i < 4; i++)
      check_eq("s3_order", 64'(i < glog.size() ? glog[i] : 7), 64'(i % 2));
    check_eq("s3_ngaps", 64'(gaps.size()), 64'(3));
    for (int i = 0; i < 3; i++) check_eq("s3_gap", 64'(i < gaps.size() ? gaps[i] : 0), 64'(2));

    // Watchdog timeout, then a normal job afterwards
    new_scenario();
    d0 = dut_done_cnt;
    never_finish = 1'b1;
    want1 = 1;
    wait_idle("s4_idle", 300);
    never_finish = 1'b0;
    check_eq("s4_err", 64'(err), 64'(1));
    check_eq("s4_cycles", 64'(cycles), 64'(TIMEOUT));
    check_eq("s4_done_cnt", 64'(dut_done_cnt - d0), 64'(1));
    want0 = 1;
    wait_idle("s4b_idle", 200);
    check_eq("s4b_err", 64'(err), 64'(1));
    check_eq("s4b_done_cnt", 64'(dut_done_cnt - d0), 64'(2));

    // Reset in the tenth RUN cycle abandons the job without a done pulse
    new_scenario();
    d0 = dut_done_cnt;
    len_lo = 20; len_hi = 30;
    rst_plan = 1'b1;
    want0 = 1;
    wait_idle("s5_idle", 200);
    check_eq("s5_no_done", 64'(dut_done_cnt - d0), 64'(0));
    check_eq("s5_err_clr", 64'(err), 64'(0));
    len_lo = 3; len_hi = 30;
    want1 = 1;
    wait_idle("s5b_idle", 200);
    check_eq("s5b_done_cnt", 64'(dut_done_cnt - d0), 64'(1));
    compare_banks();

    // Random job mixes, some with a stale finish held across START
    for (int it = 0; it < 40; it++) begin
      new_scenario();
      want0 = $urandom_range(0, 2);
      want1 = $urandom_range(0, 2);
      if (want0 == 0 && want1 == 0) want0 = 1;
      if ($urandom_range(0, 3) == 0) force_fin = 4;
      wait_idle("rnd_idle", 600);
    end
    compare_banks();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
